carry_select_adder: RTL and testbench
=====================================

CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits (legal range 1..64).
REQ-003 Parameter BLOCK_SIZE, default 4, SHALL set the carry-select block width in bits (legal range 1..WIDTH).
REQ-004 Port clk, input, 1 bit: the single clock; rising edge active.
REQ-005 Port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 Port in_valid, input, 1 bit: a, b and cin carry a valid operation in this cycle.
REQ-007 Port a, input, WIDTH bits: unsigned operand A.
REQ-008 Port b, input, WIDTH bits: unsigned operand B.
REQ-009 Port cin, input, 1 bit: carry-in.
REQ-010 Port sum, output, WIDTH bits: registered sum (a+b+cin) mod 2^WIDTH.
REQ-011 Port cout, output, 1 bit: registered carry-out, equal to bit WIDTH of a+b+cin.
REQ-012 Port out_valid, output, 1 bit: sum and cout hold a fresh result.

Function
REQ-013 The operands SHALL be split into ceil(WIDTH/BLOCK_SIZE) blocks, LSB first; the last block SHALL be narrower when WIDTH is not a multiple of BLOCK_SIZE.
REQ-014 Block 0 SHALL ripple-add using cin directly.
REQ-015 Each block k>0 SHALL compute two ripple sums in parallel, one with carry-in 0 and one with carry-in 1.
REQ-016 Each block k>0 SHALL select its sum and block carry with a mux driven by the selected carry-out of block k-1.
REQ-017 cout SHALL be the selected carry-out of the last block; the result SHALL equal the full arithmetic sum a+b+cin of width WIDTH+1.
REQ-018 Latency SHALL be 1 cycle: inputs sampled on rising edge N SHALL appear on sum, cout and out_valid after edge N.
REQ-019 out_valid SHALL register in_valid at every clock edge.
REQ-020 sum and cout SHALL update only on edges where in_valid=1 and SHALL hold their previous value otherwise.
REQ-021 Back-to-back valid inputs SHALL sustain one result per cycle, with no stalls and no backpressure.
REQ-022 Overflow SHALL wrap the sum: for example, 8'hFF+8'h01+0 SHALL give sum=0 and cout=1.

Reset
REQ-023 While rst_n=0, sum, cout and out_valid SHALL be 0, independent of clk.
REQ-024 An operation in flight when reset asserts SHALL be discarded; after reset deasserts, the first result SHALL follow the first in_valid=1 edge.

Configuration
REQ-025 When macro CSA_INPUT_REG_EN is defined, a, b, cin and in_valid SHALL be captured in an input register stage before the adder.
REQ-026 With CSA_INPUT_REG_EN defined, latency SHALL be 2 cycles and the input registers SHALL reset to 0.
REQ-027 Without CSA_INPUT_REG_EN, the adder SHALL be driven combinationally from the ports, giving 1-cycle latency.
REQ-028 Function and throughput SHALL be otherwise identical with and without CSA_INPUT_REG_EN.

Structure
REQ-029 Shared package csa_pkg SHALL hold the default WIDTH and BLOCK_SIZE constants and a function computing the number of blocks.
REQ-030 The ripple block SHALL be sub-module simple_carry_adder, with parameter WIDTH and ports a, b, cin, sum, cout; it SHALL be purely combinational.
REQ-031 carry_select_adder SHALL instantiate simple_carry_adder once for block 0 and twice for each block k>0.

Verification
REQ-032 a=100, b=50, cin=0, in_valid=1 -> one cycle later sum=150, cout=0, out_valid=1.
REQ-033 a=200, b=100, cin=1 -> sum=45, cout=1.
REQ-034 a=8'hFF, b=8'h01, cin=0 -> sum=0, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-035 Assert rst_n=0 mid-stream with in_valid=1 -> sum, cout and out_valid go to 0 immediately; the first post-reset result matches the first post-reset input.
REQ-036 WIDTH=10, BLOCK_SIZE=4, a=10'h3FF, b=1, cin=0 -> sum=0, cout=1; the narrow last block must propagate the carry.
REQ-037 Stream in_valid=1 for 4 cycles, then hold in_valid=0 -> out_valid pulses for 4 cycles and sum holds the last result; repeat with CSA_INPUT_REG_EN defined and check 2-cycle latency.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder.
// Optional input register stage is enabled with macro CSA_INPUT_REG_EN.
package csa_pkg;

    localparam int unsigned CSA_DEFAULT_WIDTH      = 8;
    localparam int unsigned CSA_DEFAULT_BLOCK_SIZE = 4;

    // Number of carry-select blocks; the last one is narrower when width is not a multiple.
    function automatic int unsigned csa_num_blocks(input int unsigned width,
                                                   input int unsigned block_size);
        return (width + block_size - 1) / block_size;
    endfunction

endpackage

// File: rtl/simple_carry_adder.sv
// Purely combinational ripple-carry adder used as one carry-select block.
// Sub-module of carry_select_adder (see CSA_INPUT_REG_EN in the top).
module simple_carry_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: ripple block 0, dual-ripple + mux for higher blocks.
// Define CSA_INPUT_REG_EN to add an input register stage (2-cycle latency).
module carry_select_adder
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH      = CSA_DEFAULT_WIDTH,
    parameter int unsigned BLOCK_SIZE = CSA_DEFAULT_BLOCK_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int unsigned NUM_BLOCKS = csa_num_blocks(WIDTH, BLOCK_SIZE);

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_valid;

`ifdef CSA_INPUT_REG_EN
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             cin_d, cin_q;
    logic             in_valid_d, in_valid_q;

    always_comb begin
        a_d        = a;
        b_d        = b;
        cin_d      = cin;
        in_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign add_valid = in_valid_q;
`else
    assign add_a     = a;
    assign add_b     = b;
    assign add_cin   = cin;
    assign add_valid = in_valid;
`endif

    logic [WIDTH-1:0] sel_sum;
    logic             add_cout;

    // Each block keeps its own carry_out scalar so the chain is not one self-dependent vector.
    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
        localparam int unsigned LO = k * BLOCK_SIZE;
        localparam int unsigned BW = ((WIDTH - LO) < BLOCK_SIZE) ? (WIDTH - LO) : BLOCK_SIZE;

        logic carry_out;

        if (k == 0) begin : g_first
            simple_carry_adder #(.WIDTH(BW)) u_add (
                .a    (add_a[LO +: BW]),
                .b    (add_b[LO +: BW]),
                .cin  (add_cin),
                .sum  (sel_sum[LO +: BW]),
                .cout (carry_out)
            );
        end else begin : g_sel
            logic          carry_in;
            logic [BW-1:0] sum0;
            logic [BW-1:0] sum1;
            logic          cout0;
            logic          cout1;

            assign carry_in = g_blk[k-1].carry_out;

            simple_carry_adder #(.WIDTH(BW)) u_add0 (
                .a    (add_a[LO +: BW]),
                .b    (add_b[LO +: BW]),
                .cin  (1'b0),
                .sum  (sum0),
                .cout (cout0)
            );

            simple_carry_adder #(.WIDTH(BW)) u_add1 (
                .a    (add_a[LO +: BW]),
                .b    (add_b[LO +: BW]),
                .cin  (1'b1),
                .sum  (sum1),
                .cout (cout1)
            );

            assign sel_sum[LO +: BW] = carry_in ? sum1 : sum0;
            assign carry_out         = carry_in ? cout1 : cout0;
        end

        if (k == NUM_BLOCKS - 1) begin : g_last
            assign add_cout = carry_out;
        end
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = add_valid;
        if (add_valid) begin
            sum_d  = sel_sum;
            cout_d = add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed self-checking bench for carry_select_adder (8-bit and 10-bit/4 instances).
// Latency expectation follows CSA_INPUT_REG_EN.
module tb_carry_select_adder;

`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       v8  = 1'b0;
    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;
    logic       c8  = 1'b0;
    logic [7:0] s8;
    logic       co8;
    logic       ov8;

    logic       v10 = 1'b0;
    logic [9:0] a10 = '0;
    logic [9:0] b10 = '0;
    logic       c10 = 1'b0;
    logic [9:0] s10;
    logic       co10;
    logic       ov10;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    carry_select_adder #(.WIDTH(8), .BLOCK_SIZE(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (c8),
        .sum       (s8),
        .cout      (co8),
        .out_valid (ov8)
    );

    carry_select_adder #(.WIDTH(10), .BLOCK_SIZE(4)) u_dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v10),
        .a         (a10),
        .b         (b10),
        .cin       (c10),
        .sum       (s10),
        .cout      (co10),
        .out_valid (ov10)
    );

    // Advance LAT falling edges, dropping in_valid after the first sampling edge.
    task automatic settle();
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            v8  = 1'b0;
            v10 = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (s8 !== 8'h00) begin miscompares++; $display("FAIL reset_sum8: got %h want 00", s8); end
        vectors++; if (co8 !== 1'b0) begin miscompares++; $display("FAIL reset_cout8: got %b want 0", co8); end
        vectors++; if (ov8 !== 1'b0) begin miscompares++; $display("FAIL reset_valid8: got %b want 0", ov8); end
        vectors++; if (s10 !== 10'h000) begin miscompares++; $display("FAIL reset_sum10: got %h want 000", s10); end
        vectors++; if (co10 !== 1'b0) begin miscompares++; $display("FAIL reset_cout10: got %b want 0", co10); end
        vectors++; if (ov10 !== 1'b0) begin miscompares++; $display("FAIL reset_valid10: got %b want 0", ov10); end
        v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ov8 !== 1'b0 || s8 !== 8'h00) begin
            miscompares++; $display("FAIL reset_held_clocked: got valid=%b sum=%h want 0/00", ov8, s8);
        end
        v8 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] va [8] = '{8'd100, 8'd200, 8'hFF, 8'hFF, 8'h00, 8'h55, 8'h0F, 8'h12};
        logic [7:0] vb [8] = '{8'd50,  8'd100, 8'h01, 8'hFF, 8'h00, 8'hAA, 8'h01, 8'h34};
        logic       vc [8] = '{1'b0,   1'b1,   1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        logic [7:0] es [8] = '{8'd150, 8'd45,  8'h00, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h46};
        logic       ec [8] = '{1'b0,   1'b1,   1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v8 = 1'b1; a8 = va[i]; b8 = vb[i]; c8 = vc[i];
            settle();
            vectors++; if (s8 !== es[i]) begin
                miscompares++; $display("FAIL basic_sum[%0d]: got %h want %h", i, s8, es[i]);
            end
            vectors++; if (co8 !== ec[i]) begin
                miscompares++; $display("FAIL basic_cout[%0d]: got %b want %b", i, co8, ec[i]);
            end
            vectors++; if (ov8 !== 1'b1) begin
                miscompares++; $display("FAIL basic_valid[%0d]: got %b want 1", i, ov8);
            end
        end
    endtask

    task automatic test_wide();
        logic [9:0] va [5] = '{10'h3FF, 10'h2AA, 10'h0F0, 10'h300, 10'h1FF};
        logic [9:0] vb [5] = '{10'h001, 10'h155, 10'h010, 10'h100, 10'h000};
        logic       vc [5] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
        logic [9:0] es [5] = '{10'h000, 10'h000, 10'h100, 10'h000, 10'h200};
        logic       ec [5] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v10 = 1'b1; a10 = va[i]; b10 = vb[i]; c10 = vc[i];
            settle();
            vectors++; if (s10 !== es[i]) begin
                miscompares++; $display("FAIL wide_sum[%0d]: got %h want %h", i, s10, es[i]);
            end
            vectors++; if (co10 !== ec[i]) begin
                miscompares++; $display("FAIL wide_cout[%0d]: got %b want %b", i, co10, ec[i]);
            end
            vectors++; if (ov10 !== 1'b1) begin
                miscompares++; $display("FAIL wide_valid[%0d]: got %b want 1", i, ov10);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sa [4] = '{8'h10, 8'h80, 8'hF0, 8'h7F};
        logic [7:0] sb [4] = '{8'h20, 8'h80, 8'h0F, 8'h01};
        logic       sc [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
        logic [7:0] es [4] = '{8'h30, 8'h00, 8'h00, 8'h80};
        logic       ec [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        int pulses = 0;
        int idx;
        int j;
        logic exp_v;
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            if (n < 4) begin
                v8 = 1'b1; a8 = sa[n]; b8 = sb[n]; c8 = sc[n];
            end else begin
                v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
            end
            @(negedge clk);
            idx = n + 1 - LAT;
            if (idx >= 0) begin
                exp_v = (idx < 4);
                j     = (idx < 4) ? idx : 3;
                if (ov8 === 1'b1) pulses++;
                vectors++; if (ov8 !== exp_v) begin
                    miscompares++; $display("FAIL stream_valid[%0d]: got %b want %b", n, ov8, exp_v);
                end
                vectors++; if (s8 !== es[j] || co8 !== ec[j]) begin
                    miscompares++;
                    $display("FAIL stream_result[%0d]: got %b/%h want %b/%h", n, co8, s8, ec[j], es[j]);
                end
            end
        end
        v8 = 1'b0;
        vectors++; if (pulses != 4) begin
            miscompares++; $display("FAIL stream_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h0A; b8 = 8'h14; c8 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (s8 !== 8'h00) begin miscompares++; $display("FAIL midrst_sum: got %h want 00", s8); end
        vectors++; if (co8 !== 1'b0) begin miscompares++; $display("FAIL midrst_cout: got %b want 0", co8); end
        vectors++; if (ov8 !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", ov8); end
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44;
        @(negedge clk);
        vectors++; if (ov8 !== 1'b0 || s8 !== 8'h00) begin
            miscompares++; $display("FAIL midrst_hold: got valid=%b sum=%h want 0/00", ov8, s8);
        end
        v8 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i <= LAT; i++) @(negedge clk);
        vectors++; if (ov8 !== 1'b0 || s8 !== 8'h00) begin
            miscompares++; $display("FAIL midrst_no_phantom: got valid=%b sum=%h want 0/00", ov8, s8);
        end
        v8 = 1'b1; a8 = 8'h21; b8 = 8'h43; c8 = 1'b1;
        settle();
        vectors++; if (s8 !== 8'h65) begin miscompares++; $display("FAIL post_rst_sum: got %h want 65", s8); end
        vectors++; if (co8 !== 1'b0) begin miscompares++; $display("FAIL post_rst_cout: got %b want 0", co8); end
        vectors++; if (ov8 !== 1'b1) begin miscompares++; $display("FAIL post_rst_valid: got %b want 1", ov8); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
